// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the client request/acknowledge bus and the transmitter control
// lines seen by the round-robin UART transmit arbiter.
// master: the arbiter itself (drives grants and transmitter controls).
// slave:  the surrounding logic (clients plus the transmitter busy flag).
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic              arb_en;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [2:0]        grant_id;
    logic              busy;
    logic              tx_err;
    logic [7:0]        Tx_DATA;
    logic              Tx_WR;
    logic              Tx_EN;
    logic              Tx_BUSY;

    modport master (
        input  arb_en, req, req_data, Tx_BUSY,
        output ack, grant_id, busy, tx_err, Tx_DATA, Tx_WR, Tx_EN
    );

    modport slave (
        output arb_en, req, req_data, Tx_BUSY,
        input  ack, grant_id, busy, tx_err, Tx_DATA, Tx_WR, Tx_EN
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler sharing the single UART transmitter between NREQ
// byte producers. One byte is accepted per transfer; the arbiter then
// follows the transmitter busy flag through its rise and fall before the
// next requester may be granted.
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a watchdog that gives up
// on a transmitter whose busy flag never rises within TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [2:0] LAST_ID = 3'(NREQ - 1);
    localparam logic [3:0] NREQ_W  = 4'(NREQ);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        ptr;
    logic [2:0]        grant_q;
    logic [7:0]        data_q;
    logic              tx_en_q;
    logic              grant_fire;
    logic              release_slot;
    logic [2*NREQ-1:0] req_twice;
    logic [NREQ-1:0]   req_rot;
    logic [3:0]        cand;
    logic              win_found;
    logic [2:0]        win_id;
    logic [7:0]        win_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] hi_cnt;
    logic             timeout_hit;
    logic             tx_err_q;
`endif

    // Rotate the request vector so ptr sits at bit 0, take the lowest set bit,
    // then map it back to an absolute requester index modulo NREQ
    always_comb begin
        req_twice = {bus.req, bus.req};
        req_rot   = NREQ'(req_twice >> ptr);
        win_found = 1'b0;
        win_id    = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                cand      = {1'b0, ptr} + 4'(k);
                if (cand >= NREQ_W) begin
                    cand = cand - NREQ_W;
                end
                win_id = cand[2:0];
            end
        end
    end

    // Pull the winner's byte out of the flattened request data bus
    always_comb begin
        win_data = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == 3'(i)) begin
                win_data = bus.req_data[8*i +: 8];
            end
        end
    end

    // Next-state logic: grant from IDLE, strobe in WR, then follow Tx_BUSY up and down
    always_comb begin
        state_nxt    = state;
        grant_fire   = 1'b0;
        release_slot = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.arb_en && win_found && !bus.Tx_BUSY) begin
                    state_nxt  = WR;
                    grant_fire = 1'b1;
                end
            end
            WR: begin
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.Tx_BUSY) begin
                    state_nxt = WAIT_LO;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (hi_cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    release_slot = 1'b1;
                    timeout_hit  = 1'b1;
                end
`endif
            end
            WAIT_LO: begin
                if (!bus.Tx_BUSY) begin
                    state_nxt    = IDLE;
                    release_slot = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, round-robin pointer and the registered transmitter-facing outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            grant_q <= 3'd0;
            data_q  <= 8'd0;
            tx_en_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_en_q <= bus.arb_en | (state_nxt != IDLE);
            if (grant_fire) begin
                data_q  <= win_data;
                grant_q <= win_id;
            end
            if (release_slot) begin
                ptr <= (grant_q == LAST_ID) ? 3'd0 : grant_q + 3'd1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: count cycles spent waiting for Tx_BUSY to rise and flag a give-up
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_cnt   <= '0;
            tx_err_q <= 1'b0;
        end else begin
            tx_err_q <= timeout_hit;
            if (state == WR) begin
                hi_cnt <= '0;
            end else if (state == WAIT_HI) begin
                hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.tx_err = tx_err_q;
`else
    assign bus.tx_err = 1'b0;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_ack
        assign bus.ack[i] = (state == WR) && (grant_q == 3'(i));
    end

    assign bus.Tx_WR    = (state == WR);
    assign bus.Tx_DATA  = data_q;
    assign bus.Tx_EN    = tx_en_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a random
// request mix, checked against a round-robin reference model and a simple
// transmitter model. Define UART_ARB_TIMEOUT_EN to exercise the watchdog.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;

    uart_tx_arbiter_if #(.NREQ(NREQ)) arb_bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (arb_bus)
    );

    always #5 clk = ~clk;

    int         vectors    = 0;
    int         miscompares = 0;
    int         model_ptr  = 0;
    int         tx_mode    = 1;
    int         frame_len  = 10;
    logic       ext_busy   = 1'b0;
    logic [7:0] data_of [NREQ];

    // Reference arbitration rule: first requester at or after p, modulo NREQ
    function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_data();
        for (int i = 0; i < NREQ; i++) arb_bus.req_data[8*i +: 8] = data_of[i];
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic wait_wr(input int limit, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
            if (arb_bus.Tx_WR === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(posedge clk); #1;
            n++;
            if (arb_bus.busy === 1'b0) ok = 1'b1;
        end
    endtask

    // Transmitter model: busy rises 2 cycles after a write strobe and stays high
    // for frame_len cycles; in mode 0 the flag simply follows ext_busy
    initial begin
        int pre;
        int hold;
        pre  = 0;
        hold = 0;
        arb_bus.Tx_BUSY = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (tx_mode == 0) begin
                pre  = 0;
                hold = 0;
                arb_bus.Tx_BUSY = ext_busy;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) arb_bus.Tx_BUSY = 1'b0;
                end else if (pre > 0) begin
                    pre--;
                    if (pre == 0) begin
                        arb_bus.Tx_BUSY = 1'b1;
                        hold = frame_len;
                    end
                end
                if (arb_bus.Tx_WR === 1'b1) pre = 2;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        arb_bus.arb_en = 1'b1;
        arb_bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) data_of[i] = 8'($urandom);
        set_data();
        repeat (3) begin @(posedge clk); #1; end
        vectors += 7;
        if (arb_bus.ack !== '0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 0", arb_bus.ack); end
        if (arb_bus.grant_id !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", arb_bus.grant_id); end
        if (arb_bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", arb_bus.busy); end
        if (arb_bus.tx_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_err: got %b expected 0", arb_bus.tx_err); end
        if (arb_bus.Tx_DATA !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 00", arb_bus.Tx_DATA); end
        if (arb_bus.Tx_WR !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_wr: got %b expected 0", arb_bus.Tx_WR); end
        if (arb_bus.Tx_EN !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_en: got %b expected 0", arb_bus.Tx_EN); end
        arb_bus.req = '0;
        reset = 1'b1;
        model_ptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_byte();
        data_of[0] = 8'hA5;
        set_data();
        arb_bus.arb_en = 1'b1;
        arb_bus.req = 4'b0001;
        @(posedge clk); #1;
        vectors += 4;
        if (arb_bus.Tx_WR !== 1'b1) begin miscompares++; $display("[TB] FAIL single_wr_latency: got %b expected 1", arb_bus.Tx_WR); end
        if (arb_bus.Tx_DATA !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_data: got %h expected a5", arb_bus.Tx_DATA); end
        if (arb_bus.ack !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_ack: got %b expected 0001", arb_bus.ack); end
        if (arb_bus.grant_id !== 3'd0) begin miscompares++; $display("[TB] FAIL single_grant: got %0d expected 0", arb_bus.grant_id); end
        arb_bus.req = '0;
        model_ptr = 1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                vectors++;
                if (arb_bus.Tx_WR !== 1'b0) begin miscompares++; $display("[TB] FAIL single_wr_width: got %b expected 0", arb_bus.Tx_WR); end
            end
            vectors++;
            if (arb_bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_c%0d: got %b expected 1", c, arb_bus.busy); end
        end
        @(posedge clk); #1;
        vectors += 2;
        if (arb_bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_fall: got %b expected 0", arb_bus.busy); end
        if (arb_bus.Tx_EN !== 1'b1) begin miscompares++; $display("[TB] FAIL single_tx_en: got %b expected 1", arb_bus.Tx_EN); end
    endtask

    task automatic test_round_robin();
        int exp_ids [5] = '{0, 1, 2, 3, 0};
        int cyc;
        bit seen;
        pulse_reset();
        model_ptr = 0;
        for (int i = 0; i < NREQ; i++) data_of[i] = 8'h10 + 8'(i);
        set_data();
        arb_bus.arb_en = 1'b1;
        arb_bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_wr(100, cyc, seen);
            vectors++;
            if (!seen) begin
                miscompares++; $display("[TB] FAIL rr_timeout_%0d: got no Tx_WR expected one within 100 cycles", n);
                break;
            end
            vectors += 5;
            if (arb_bus.grant_id !== 3'(exp_ids[n])) begin miscompares++; $display("[TB] FAIL rr_grant_%0d: got %0d expected %0d", n, arb_bus.grant_id, exp_ids[n]); end
            if (arb_bus.Tx_DATA !== 8'h10 + 8'(exp_ids[n])) begin miscompares++; $display("[TB] FAIL rr_data_%0d: got %h expected %h", n, arb_bus.Tx_DATA, 8'h10 + 8'(exp_ids[n])); end
            if (arb_bus.ack !== 4'(1 << exp_ids[n])) begin miscompares++; $display("[TB] FAIL rr_ack_%0d: got %b expected %b", n, arb_bus.ack, 4'(1 << exp_ids[n])); end
            if (!$onehot(arb_bus.ack)) begin miscompares++; $display("[TB] FAIL rr_onehot_%0d: got %b expected one-hot", n, arb_bus.ack); end
            if (cyc !== ((n == 0) ? 1 : 4 + frame_len)) begin miscompares++; $display("[TB] FAIL rr_spacing_%0d: got %0d expected %0d", n, cyc, (n == 0) ? 1 : 4 + frame_len); end
        end
        arb_bus.req = '0;
        model_ptr = 1;
        wait_idle(100, seen);
        vectors++;
        if (!seen) begin miscompares++; $display("[TB] FAIL rr_idle: got busy expected idle within 100 cycles"); end
    endtask

    task automatic test_wrap_skip();
        int cyc;
        int exp_g;
        bit seen;
        logic [NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) data_of[i] = 8'($urandom);
        set_data();
        r = 4'b0100;
        arb_bus.req = r;
        for (int n = 0; n < 3; n++) begin
            exp_g = rr_pick(model_ptr, r);
            wait_wr(100, cyc, seen);
            vectors += 3;
            if (!seen) begin miscompares++; $display("[TB] FAIL wrap_timeout_%0d: got no Tx_WR expected grant %0d", n, exp_g); end
            if (arb_bus.grant_id !== 3'(exp_g)) begin miscompares++; $display("[TB] FAIL wrap_grant_%0d: got %0d expected %0d", n, arb_bus.grant_id, exp_g); end
            if (arb_bus.Tx_DATA !== data_of[exp_g]) begin miscompares++; $display("[TB] FAIL wrap_data_%0d: got %h expected %h", n, arb_bus.Tx_DATA, data_of[exp_g]); end
            model_ptr = (exp_g + 1) % NREQ;
            if (n == 0) begin
                arb_bus.req = '0;
                wait_idle(100, seen);
                r = 4'b0101;
                arb_bus.req = r;
            end
        end
        arb_bus.req = '0;
        wait_idle(100, seen);
    endtask

    task automatic test_arb_en_drop();
        int cyc;
        int wr_count;
        int exp_g;
        bit seen;
        bit done;
        arb_bus.arb_en = 1'b1;
        arb_bus.req = 4'b1111;
        exp_g = rr_pick(model_ptr, 4'b1111);
        wait_wr(100, cyc, seen);
        vectors += 2;
        if (!seen) begin miscompares++; $display("[TB] FAIL drop_first_wr: got none expected grant"); end
        if (arb_bus.grant_id !== 3'(exp_g)) begin miscompares++; $display("[TB] FAIL drop_grant: got %0d expected %0d", arb_bus.grant_id, exp_g); end
        model_ptr = (exp_g + 1) % NREQ;
        @(posedge clk); #1;
        arb_bus.arb_en = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            vectors++;
            if (arb_bus.busy === 1'b1) begin
                if (arb_bus.Tx_EN !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_tx_en_hold: got %b expected 1", arb_bus.Tx_EN); end
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
                if (arb_bus.Tx_EN !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_tx_en_low: got %b expected 0", arb_bus.Tx_EN); end
            end
        end
        vectors++;
        if (!done) begin miscompares++; $display("[TB] FAIL drop_frame_end: got busy expected idle within 50 cycles"); end
        wr_count = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (arb_bus.Tx_WR === 1'b1) wr_count++;
        end
        vectors++;
        if (wr_count !== 0) begin miscompares++; $display("[TB] FAIL drop_no_grant: got %0d writes expected 0", wr_count); end
        arb_bus.req = '0;
        arb_bus.arb_en = 1'b1;
    endtask

    task automatic test_ext_busy();
        int cyc;
        int wr_count;
        bit seen;
        tx_mode = 0;
        ext_busy = 1'b1;
        arb_bus.req = 4'b0010;
        wr_count = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (arb_bus.Tx_WR === 1'b1) wr_count++;
        end
        vectors += 2;
        if (wr_count !== 0) begin miscompares++; $display("[TB] FAIL ext_busy_block: got %0d writes expected 0", wr_count); end
        if (arb_bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ext_busy_idle: got %b expected 0", arb_bus.busy); end
        ext_busy = 1'b0;
        wait_wr(20, cyc, seen);
        vectors += 2;
        if (!seen || cyc !== 1) begin miscompares++; $display("[TB] FAIL ext_busy_release: got seen=%0d after %0d cycles expected 1 cycle", seen, cyc); end
        if (arb_bus.grant_id !== 3'(rr_pick(model_ptr, 4'b0010))) begin miscompares++; $display("[TB] FAIL ext_busy_grant: got %0d expected %0d", arb_bus.grant_id, rr_pick(model_ptr, 4'b0010)); end
        model_ptr = 2;
        arb_bus.req = '0;
        ext_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        ext_busy = 1'b0;
        wait_idle(50, seen);
        tx_mode = 1;
    endtask

    task automatic test_timeout();
        int cyc;
        int exp_g;
        bit seen;
        tx_mode = 0;
        ext_busy = 1'b0;
        arb_bus.req = 4'b1111;
        exp_g = rr_pick(model_ptr, 4'b1111);
        wait_wr(50, cyc, seen);
        vectors += 2;
        if (!seen) begin miscompares++; $display("[TB] FAIL to_first_wr: got none expected grant"); end
        if (arb_bus.grant_id !== 3'(exp_g)) begin miscompares++; $display("[TB] FAIL to_grant: got %0d expected %0d", arb_bus.grant_id, exp_g); end
        model_ptr = (exp_g + 1) % NREQ;
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (arb_bus.tx_err !== 1'b0 || arb_bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL to_wait_c%0d: got err=%b busy=%b expected err=0 busy=1", c, arb_bus.tx_err, arb_bus.busy); end
        end
        @(posedge clk); #1;
        vectors++;
        if (arb_bus.tx_err !== 1'b1 || arb_bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL to_pulse: got err=%b busy=%b expected err=1 busy=0", arb_bus.tx_err, arb_bus.busy); end
        @(posedge clk); #1;
        vectors += 2;
        if (arb_bus.tx_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_pulse_width: got %b expected 0", arb_bus.tx_err); end
        if (arb_bus.Tx_WR !== 1'b1 || arb_bus.grant_id !== 3'(model_ptr)) begin miscompares++; $display("[TB] FAIL to_next_grant: got wr=%b id=%0d expected wr=1 id=%0d", arb_bus.Tx_WR, arb_bus.grant_id, model_ptr); end
        model_ptr = (model_ptr + 1) % NREQ;
        arb_bus.req = '0;
        ext_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        ext_busy = 1'b0;
        wait_idle(50, seen);
`else
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (arb_bus.tx_err !== 1'b0 || arb_bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_c%0d: got err=%b busy=%b expected err=0 busy=1", c, arb_bus.tx_err, arb_bus.busy); end
        end
        arb_bus.req = '0;
        pulse_reset();
        model_ptr = 0;
`endif
        tx_mode = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        for (int i = 0; i < NREQ; i++) data_of[i] = 8'($urandom);
        set_data();
        arb_bus.req = 4'b1111;
        wait_wr(100, cyc, seen);
        repeat (6) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors += 4;
        if (arb_bus.busy !== 1'b0 || arb_bus.Tx_WR !== 1'b0 || arb_bus.ack !== '0) begin miscompares++; $display("[TB] FAIL mid_reset_ctrl: got busy=%b wr=%b ack=%b expected all 0", arb_bus.busy, arb_bus.Tx_WR, arb_bus.ack); end
        if (arb_bus.Tx_DATA !== 8'h00 || arb_bus.grant_id !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_reset_data: got data=%h id=%0d expected 00/0", arb_bus.Tx_DATA, arb_bus.grant_id); end
        if (arb_bus.Tx_EN !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_tx_en: got %b expected 0", arb_bus.Tx_EN); end
        if (arb_bus.tx_err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_tx_err: got %b expected 0", arb_bus.tx_err); end
        reset = 1'b1;
        model_ptr = 0;
        wait_wr(100, cyc, seen);
        vectors += 2;
        if (!seen || cyc !== 6) begin miscompares++; $display("[TB] FAIL mid_regrant_time: got seen=%0d cycles=%0d expected 6", seen, cyc); end
        if (arb_bus.grant_id !== 3'd0 || arb_bus.Tx_DATA !== data_of[0]) begin miscompares++; $display("[TB] FAIL mid_regrant: got id=%0d data=%h expected 0/%h", arb_bus.grant_id, arb_bus.Tx_DATA, data_of[0]); end
        model_ptr = 1;
        arb_bus.req = '0;
        wait_idle(100, seen);
    endtask

    task automatic test_random();
        int cyc;
        int exp_g;
        int prev_frame;
        bit seen;
        logic [NREQ-1:0] r;
        r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) data_of[i] = 8'($urandom);
        set_data();
        arb_bus.req = r;
        prev_frame = frame_len;
        for (int n = 0; n < 24; n++) begin
            exp_g = rr_pick(model_ptr, r);
            wait_wr(200, cyc, seen);
            vectors += 4;
            if (!seen) begin miscompares++; $display("[TB] FAIL rand_timeout_%0d: got no Tx_WR expected grant %0d", n, exp_g); break; end
            if (arb_bus.grant_id !== 3'(exp_g)) begin miscompares++; $display("[TB] FAIL rand_grant_%0d: got %0d expected %0d", n, arb_bus.grant_id, exp_g); end
            if (arb_bus.Tx_DATA !== data_of[exp_g]) begin miscompares++; $display("[TB] FAIL rand_data_%0d: got %h expected %h", n, arb_bus.Tx_DATA, data_of[exp_g]); end
            if (arb_bus.ack !== 4'(1 << exp_g)) begin miscompares++; $display("[TB] FAIL rand_ack_%0d: got %b expected %b", n, arb_bus.ack, 4'(1 << exp_g)); end
            if (n > 0) begin
                vectors++;
                if (cyc !== 4 + prev_frame) begin miscompares++; $display("[TB] FAIL rand_spacing_%0d: got %0d expected %0d", n, cyc, 4 + prev_frame); end
            end
            model_ptr = (exp_g + 1) % NREQ;
            frame_len = $urandom_range(1, 6);
            prev_frame = frame_len;
            r[exp_g] = 1'($urandom_range(0, 1));
            data_of[exp_g] = 8'($urandom);
            if (r == '0) r[$urandom_range(0, NREQ - 1)] = 1'b1;
            set_data();
            arb_bus.req = r;
        end
        arb_bus.req = '0;
        wait_idle(100, seen);
        frame_len = 10;
    endtask

    initial begin
        reset = 1'b0;
        arb_bus.arb_en = 1'b0;
        arb_bus.req = '0;
        arb_bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) data_of[i] = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        $display("[TB] starting uart_tx_arbiter checks");
        test_reset();
        test_single_byte();
        test_round_robin();
        test_wrap_skip();
        test_arb_en_drop();
        test_ext_busy();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
